md_hilo_ctrl: RTL and testbench

- Sequencer for the execute-stage multiplier, the multi-cycle divider and the architectural HI/LO register pair.
- Accepts MULT/DIV/MTHI/MTLO requests from decode and latches operands for the arithmetic units.
- Issues the divider start pulse, waits out the unit latency and commits results to HI/LO.
- Stalls the front of the pipeline while a HI/LO consumer or a new request would collide with an operation in flight.

---
 rtl/md_hilo_ctrl.sv | 160 ++++++++++++++++
 tb/tb_md_hilo_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_hilo_ctrl.sv
// Multiply/divide sequencer and HI/LO register pair for the execute stage.
// Optional macro MD_HILO_BYPASS_EN forwards completing results onto hi/lo and shortens MFHI/MFLO stalls.
module md_hilo_ctrl #(
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic        req_signed,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        hilo_rd_req,
  input  logic        flush,
  input  logic [63:0] mul_result,
  input  logic        div_complete,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic [31:0] md_src1,
  output logic [31:0] md_src2,
  output logic        md_signed,
  output logic        div_start,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MUL_WAIT  = 2'd1,
    DIV_WAIT  = 2'd2,
    DIV_DRAIN = 2'd3
  } state_t;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 1);

  state_t      state_q, state_d;
  logic [31:0] md_src1_q, md_src1_d;
  logic [31:0] md_src2_q, md_src2_d;
  logic        md_signed_q, md_signed_d;
  logic        div_start_q, div_start_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [3:0]  mul_cnt_q, mul_cnt_d;

  always_comb begin
    state_d     = state_q;
    md_src1_d   = md_src1_q;
    md_src2_d   = md_src2_q;
    md_signed_d = md_signed_q;
    div_start_d = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mul_cnt_d   = mul_cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          case (req_op)
            OP_MULT: begin
              md_src1_d   = src1;
              md_src2_d   = src2;
              md_signed_d = req_signed;
              mul_cnt_d   = MUL_CNT_INIT;
              state_d     = MUL_WAIT;
            end
            OP_DIV: begin
              md_src1_d   = src1;
              md_src2_d   = src2;
              md_signed_d = req_signed;
              div_start_d = 1'b1;
              state_d     = DIV_WAIT;
            end
            OP_MTHI: hi_d = src1;
            OP_MTLO: lo_d = src1;
            default: ;
          endcase
        end
      end
      MUL_WAIT: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mul_cnt_q == 4'd0) begin
          hi_d    = mul_result[63:32];
          lo_d    = mul_result[31:0];
          state_d = IDLE;
        end else begin
          mul_cnt_d = mul_cnt_q - 4'd1;
        end
      end
      DIV_WAIT: begin
        // div_start_q marks the start cycle, where a completion pulse is stale
        if (flush) begin
          state_d = DIV_DRAIN;
        end else if (div_complete && !div_start_q) begin
          lo_d    = div_quotient;
          hi_d    = div_remainder;
          state_d = IDLE;
        end
      end
      DIV_DRAIN: begin
        if (div_complete) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      md_src1_q   <= 32'd0;
      md_src2_q   <= 32'd0;
      md_signed_q <= 1'b0;
      div_start_q <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      mul_cnt_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      md_src1_q   <= md_src1_d;
      md_src2_q   <= md_src2_d;
      md_signed_q <= md_signed_d;
      div_start_q <= div_start_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mul_cnt_q   <= mul_cnt_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign md_src1   = md_src1_q;
  assign md_src2   = md_src2_q;
  assign md_signed = md_signed_q;
  assign div_start = div_start_q;

`ifdef MD_HILO_BYPASS_EN
  logic hilo_commit;

  // In the completion cycle hi_d/lo_d already carry the incoming result
  assign hilo_commit = !flush &&
                       ((state_q == MUL_WAIT && mul_cnt_q == 4'd0) ||
                        (state_q == DIV_WAIT && !div_start_q && div_complete));
  assign hi    = hilo_commit ? hi_d : hi_q;
  assign lo    = hilo_commit ? lo_d : lo_q;
  assign stall = busy & (req_valid | (hilo_rd_req & ~hilo_commit));
`else
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = busy & (req_valid | hilo_rd_req);
`endif

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Self-checking bench for md_hilo_ctrl: vector table, directed corner sequences,
// then random traffic against a cycle-level reference model.
module tb_md_hilo_ctrl;

  localparam int LAT = 2;
`ifdef MD_HILO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  localparam int K_MUL = 0;
  localparam int K_DIV = 1;
  localparam int K_DRAIN = 2;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic [1:0]  req_op;
  logic        req_signed;
  logic [31:0] src1, src2;
  logic        hilo_rd_req;
  logic        flush;
  logic [63:0] mul_result;
  logic        div_complete;
  logic [31:0] div_quotient, div_remainder;
  logic [31:0] md_src1, md_src2;
  logic        md_signed, div_start, stall, busy;
  logic [31:0] hi, lo;

  md_hilo_ctrl #(.MUL_LATENCY(LAT)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
    .req_signed(req_signed), .src1(src1), .src2(src2), .hilo_rd_req(hilo_rd_req),
    .flush(flush), .mul_result(mul_result), .div_complete(div_complete),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .md_src1(md_src1), .md_src2(md_src2), .md_signed(md_signed),
    .div_start(div_start), .stall(stall), .busy(busy), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  function automatic logic [63:0] mul64(logic [31:0] a, logic [31:0] b, logic sg);
    logic signed [63:0] sa, sb;
    if (sg) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Multiplier: result is always ready for whatever operands are latched
  assign mul_result = mul64(md_src1, md_src2, md_signed);

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model state
  bit          m_busy, m_first, m_sgn, m_commit;
  int          m_kind, m_left;
  logic [31:0] m_hi, m_lo, m_a, m_b, m_nhi, m_nlo;
  bit          e_busy, e_stall, e_dstart;
  logic [31:0] e_hi, e_lo;

  // Divider model: fires div_complete dv_delay cycles after the start cycle
  int          dv_cnt, dv_delay;
  bit          dv_new;
  logic [31:0] dv_q, dv_r;

  task automatic div_ref(logic [31:0] a, logic [31:0] b, logic sg);
    if (b == 32'd0) begin
      dv_q = 32'hFFFF_FFFF;
      dv_r = a;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      dv_q = a;
      dv_r = 32'd0;
    end else if (sg) begin
      dv_q = 32'($signed(a) / $signed(b));
      dv_r = 32'($signed(a) % $signed(b));
    end else begin
      dv_q = a / b;
      dv_r = a % b;
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_first = 0; m_sgn = 0; m_kind = K_MUL; m_left = 0;
    m_hi = 0; m_lo = 0; m_a = 0; m_b = 0;
    dv_cnt = 0; dv_new = 0;
  endtask

  task automatic model_eval();
    m_commit = 0;
    m_nhi = m_hi;
    m_nlo = m_lo;
    if (m_busy && m_kind == K_MUL && m_left == 1 && !flush) begin
      m_commit = 1;
      {m_nhi, m_nlo} = mul64(m_a, m_b, m_sgn);
    end
    if (m_busy && m_kind == K_DIV && !m_first && div_complete && !flush) begin
      m_commit = 1;
      m_nhi = div_remainder;
      m_nlo = div_quotient;
    end
    e_busy   = m_busy;
    e_dstart = m_busy && m_kind == K_DIV && m_first;
    e_stall  = m_busy && (req_valid || (hilo_rd_req && !(BYP && m_commit)));
    e_hi     = (BYP && m_commit) ? m_nhi : m_hi;
    e_lo     = (BYP && m_commit) ? m_nlo : m_lo;
  endtask

  // Advance the model across the edge, clock, then run the divider model
  task automatic clk_cycle();
    model_eval();
    if (!m_busy) begin
      if (req_valid && !flush) begin
        case (req_op)
          OP_MULT: begin
            m_a = src1; m_b = src2; m_sgn = req_signed;
            m_busy = 1; m_kind = K_MUL; m_left = LAT;
          end
          OP_DIV: begin
            m_a = src1; m_b = src2; m_sgn = req_signed;
            m_busy = 1; m_kind = K_DIV; m_first = 1;
            div_ref(src1, src2, req_signed);
            dv_new = 1;
          end
          OP_MTHI: m_hi = src1;
          default: m_lo = src1;
        endcase
      end
    end else begin
      case (m_kind)
        K_MUL: begin
          if (flush) m_busy = 0;
          else if (m_commit) begin m_hi = m_nhi; m_lo = m_nlo; m_busy = 0; end
          else m_left--;
        end
        K_DIV: begin
          m_first = 0;
          if (flush) m_kind = K_DRAIN;
          else if (m_commit) begin m_hi = m_nhi; m_lo = m_nlo; m_busy = 0; end
        end
        default: if (div_complete) m_busy = 0;
      endcase
    end
    @(posedge clk);
    #1;
    div_complete = 1'b0;
    if (dv_cnt > 0) begin
      dv_cnt--;
      if (dv_cnt == 0) begin
        div_complete  = 1'b1;
        div_quotient  = dv_q;
        div_remainder = dv_r;
      end
    end
    if (dv_new) begin
      dv_cnt = dv_delay;
      dv_new = 0;
    end
  endtask

  task automatic drive(bit rv, logic [1:0] op, bit sg, logic [31:0] a, logic [31:0] b, bit rd, bit fl);
    req_valid = rv; req_op = op; req_signed = sg; src1 = a; src2 = b;
    hilo_rd_req = rd; flush = fl;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(0, OP_MULT, 0, 0, 0, 0, 0);
    div_complete = 0; div_quotient = 0; div_remainder = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic check_model(string tag);
    chk({tag, ".busy"},      busy,      e_busy);
    chk({tag, ".stall"},     stall,     e_stall);
    chk({tag, ".div_start"}, div_start, e_dstart);
    chk({tag, ".hi"},        hi,        e_hi);
    chk({tag, ".lo"},        lo,        e_lo);
    chk({tag, ".md_src1"},   md_src1,   m_a);
    chk({tag, ".md_src2"},   md_src2,   m_b);
    chk({tag, ".md_signed"}, md_signed, m_sgn);
  endtask

  typedef struct {
    logic rv; logic [1:0] op; logic sg; logic [31:0] a, b; logic rd, fl;
    logic [31:0] ehi, elo; logic estall, ebusy;
  } vec_t;

  function automatic vec_t mk(logic rv, logic [1:0] op, logic sg, logic [31:0] a, logic [31:0] b,
                              logic rd, logic fl, logic [31:0] ehi, logic [31:0] elo,
                              logic estall, logic ebusy);
    vec_t v;
    v.rv = rv; v.op = op; v.sg = sg; v.a = a; v.b = b; v.rd = rd; v.fl = fl;
    v.ehi = ehi; v.elo = elo; v.estall = estall; v.ebusy = ebusy;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    tbl[0]  = mk(1, OP_MTHI, 0, 32'hA5A5A5A5, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    tbl[1]  = mk(1, OP_MTLO, 0, 32'h5A5A5A5A, 0, 0, 0, 32'hA5A5A5A5, 32'h0, 0, 0);
    tbl[2]  = mk(0, OP_MULT, 0, 0, 0, 1, 0, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0);
    tbl[3]  = mk(1, OP_MULT, 1, 32'hFFFFFFFD, 32'd7, 1, 0, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0);
    tbl[4]  = mk(0, OP_MULT, 0, 0, 0, 1, 0, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 1);
    tbl[5]  = mk(0, OP_MULT, 0, 0, 0, 1, 0, BYP ? 32'hFFFFFFFF : 32'hA5A5A5A5,
                 BYP ? 32'hFFFFFFEB : 32'h5A5A5A5A, !BYP, 1);
    tbl[6]  = mk(0, OP_MULT, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0);
    tbl[7]  = mk(1, OP_MULT, 0, 32'hFFFFFFFF, 32'd2, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0);
    tbl[8]  = mk(0, OP_MULT, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0);
    tbl[9]  = mk(1, OP_MULT, 0, 32'h10000, 32'h10000, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0);
    tbl[10] = mk(0, OP_MULT, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 1);
    tbl[11] = mk(0, OP_MULT, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0);
    tbl[12] = mk(1, OP_MULT, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0);
    tbl[13] = mk(0, OP_MULT, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 1);
    tbl[14] = mk(0, OP_MULT, 0, 0, 0, 0, 0, BYP ? 32'hFFFFFFFE : 32'hFFFFFFFF,
                 BYP ? 32'h1 : 32'hFFFFFFEB, 0, 1);
    tbl[15] = mk(0, OP_MULT, 0, 0, 0, 0, 0, 32'hFFFFFFFE, 32'h1, 0, 0);

    dv_delay = 4;
    do_reset();
    #1;
    chk("reset.busy", busy, 0);
    chk("reset.hi", hi, 0);
    chk("reset.lo", lo, 0);
    chk("reset.div_start", div_start, 0);

    // Vector table: MTHI/MTLO, signed MULT, flushes in IDLE and MUL_WAIT
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rv, tbl[i].op, tbl[i].sg, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].fl);
      #1;
      chk($sformatf("tbl%0d.hi", i), hi, tbl[i].ehi);
      chk($sformatf("tbl%0d.lo", i), lo, tbl[i].elo);
      chk($sformatf("tbl%0d.stall", i), stall, tbl[i].estall);
      chk($sformatf("tbl%0d.busy", i), busy, tbl[i].ebusy);
      clk_cycle();
    end

    // DIV 100/7 unsigned, completion 33 cycles after accept, MFHI held
    dv_delay = 32;
    drive(1, OP_DIV, 0, 32'd100, 32'd7, 1, 0);
    #1;
    chk("divA.accept_stall", stall, 0);
    clk_cycle();
    drive(0, OP_MULT, 0, 0, 0, 1, 0);
    #1;
    chk("divA.div_start1", div_start, 1);
    chk("divA.md_src1", md_src1, 32'd100);
    chk("divA.md_src2", md_src2, 32'd7);
    clk_cycle();
    for (int c = 2; c <= 33; c++) begin
      #1;
      chk($sformatf("divA.busy@%0d", c), busy, 1);
      chk($sformatf("divA.div_start@%0d", c), div_start, 0);
      chk($sformatf("divA.stall@%0d", c), stall, (c == 33 && BYP) ? 1'b0 : 1'b1);
      chk($sformatf("divA.hi@%0d", c), hi, (c == 33 && BYP) ? 32'd2 : 32'hFFFFFFFE);
      clk_cycle();
    end
    #1;
    chk("divA.busy_after", busy, 0);
    chk("divA.stall_after", stall, 0);
    chk("divA.lo", lo, 32'd14);
    chk("divA.hi", hi, 32'd2);

    // Completion pulse in the start cycle must be ignored
    dv_delay = 3;
    drive(1, OP_DIV, 0, 32'd9, 32'd2, 0, 0);
    clk_cycle();
    drive(0, OP_MULT, 0, 0, 0, 0, 0);
    div_complete = 1; div_quotient = 32'hDEAD; div_remainder = 32'hBEEF;
    #1;
    chk("divB.div_start", div_start, 1);
    clk_cycle();
    #1;
    chk("divB.busy_after_stale", busy, 1);
    chk("divB.hi_kept", hi, 32'd2);
    chk("divB.lo_kept", lo, 32'd14);
    clk_cycle();
    clk_cycle();
    clk_cycle();
    #1;
    chk("divB.busy_done", busy, 0);
    chk("divB.lo", lo, 32'd4);
    chk("divB.hi", hi, 32'd1);

    // Flush in DIV_WAIT cycle 3: drain, discard result, MULT held until done
    dv_delay = 8;
    drive(1, OP_DIV, 0, 32'd50, 32'd5, 0, 0);
    clk_cycle();
    drive(0, OP_MULT, 0, 0, 0, 0, 0);
    clk_cycle();
    clk_cycle();
    drive(0, OP_MULT, 0, 0, 0, 0, 1);
    #1;
    chk("divC.busy_flush", busy, 1);
    clk_cycle();
    drive(1, OP_MULT, 0, 32'd3, 32'd4, 0, 0);
    for (int c = 4; c <= 9; c++) begin
      #1;
      chk($sformatf("divC.stall@%0d", c), stall, 1);
      chk($sformatf("divC.hi@%0d", c), hi, 32'd1);
      chk($sformatf("divC.lo@%0d", c), lo, 32'd4);
      clk_cycle();
    end
    #1;
    chk("divC.busy_idle", busy, 0);
    chk("divC.stall_idle", stall, 0);
    chk("divC.hi_discard", hi, 32'd1);
    chk("divC.lo_discard", lo, 32'd4);
    clk_cycle();
    drive(0, OP_MULT, 0, 0, 0, 0, 0);
    #1;
    chk("divC.mul_busy", busy, 1);
    chk("divC.mul_src1", md_src1, 32'd3);
    clk_cycle();
    clk_cycle();
    #1;
    chk("divC.mul_hi", hi, 32'd0);
    chk("divC.mul_lo", lo, 32'd12);

    // MULT 6*7 presented while a DIV is in flight
    dv_delay = 4;
    drive(1, OP_DIV, 0, 32'd100, 32'd7, 0, 0);
    clk_cycle();
    drive(1, OP_MULT, 0, 32'd6, 32'd7, 0, 0);
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("busyD.stall@%0d", c), stall, 1);
      clk_cycle();
    end
    #1;
    chk("busyD.stall_idle", stall, 0);
    chk("busyD.lo_div", lo, 32'd14);
    chk("busyD.hi_div", hi, 32'd2);
    clk_cycle();
    drive(0, OP_MULT, 0, 0, 0, 0, 0);
    clk_cycle();
    clk_cycle();
    #1;
    chk("busyD.hi", hi, 32'd0);
    chk("busyD.lo", lo, 32'd42);

    // Asynchronous reset in the first DIV_WAIT cycle
    dv_delay = 5;
    drive(1, OP_DIV, 1, 32'hFFFFFFF8, 32'd2, 0, 0);
    clk_cycle();
    drive(1, OP_MULT, 0, 32'd1, 32'd1, 1, 0);
    #1;
    chk("rstE.div_start_pre", div_start, 1);
    chk("rstE.stall_pre", stall, 1);
    #1;
    resetn = 1'b0;
    #1;
    chk("rstE.busy", busy, 0);
    chk("rstE.stall", stall, 0);
    chk("rstE.div_start", div_start, 0);
    chk("rstE.hi", hi, 0);
    chk("rstE.lo", lo, 0);
    chk("rstE.md_src1", md_src1, 0);
    do_reset();

    // Random traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      req_valid   = ($urandom_range(0, 1) == 1);
      req_op      = 2'($urandom_range(0, 3));
      req_signed  = ($urandom_range(0, 1) == 1);
      src1        = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 100)) - 32'd50;
      src2        = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10;
      hilo_rd_req = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 11) == 0);
      dv_delay    = $urandom_range(1, 6);
      #1;
      model_eval();
      check_model($sformatf("rnd%0d", n));
      clk_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
